// File: rtl/crc_pkg.sv
// Shared definitions for the bit-serial CRC-16 engine: state encoding, CCITT defaults and
// the single-bit CRC step used by both the engine and its reference model.
package crc_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FRAME = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StFrame = ST_FRAME,
        StShift = ST_SHIFT,
        StDone  = ST_DONE
    } crc_state_e;

    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
    localparam logic [15:0] CRC16_CCITT_INIT = 16'hFFFF;

    // One MSB-first step of a 16-bit CRC; the x^16 term is implicit.
    function automatic logic [15:0] crc16_bit_step(input logic [15:0] crc,
                                                   input logic        data_bit,
                                                   input logic [15:0] poly);
        logic fb;
        fb = crc[15] ^ data_bit;
        return {crc[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
    endfunction

endpackage

// File: rtl/crc16_engine.sv
// Bit-serial CRC-16 engine: takes a byte frame over valid/ready, folds one bit per clock and
// publishes the result with a single-cycle done pulse that feeds a downstream toggle crossing.
module crc16_engine
    import crc_pkg::*;
#(
    parameter logic [15:0] POLY   = CRC16_CCITT_POLY,
    parameter logic [15:0] INIT   = CRC16_CCITT_INIT,
    parameter logic [15:0] XOROUT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [7:0]  din_i,
    input  logic        din_valid_i,
    input  logic        din_last_i,
    output logic        din_ready_o,
    output logic [15:0] crc_out_o,
    output logic        done_o,
    output logic        busy_o
);

    crc_state_e  state_q, state_d;
    logic [15:0] crc_q, crc_d;
    logic [15:0] crc_out_q, crc_out_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        last_q, last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            crc_q     <= 16'h0000;
            crc_out_q <= 16'h0000;
            shreg_q   <= 8'h00;
            bitcnt_q  <= 3'd0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            crc_out_q <= crc_out_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            last_q    <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        crc_out_d = crc_out_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        last_d    = last_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    crc_d   = INIT;
                    state_d = StFrame;
                end
            end
            StFrame: begin
                // din_ready_o is high exactly in this state, so valid alone completes the handshake.
                if (din_valid_i) begin
                    shreg_d  = din_i;
                    last_d   = din_last_i;
                    bitcnt_d = 3'd0;
                    state_d  = StShift;
                end
            end
            StShift: begin
                crc_d    = crc16_bit_step(crc_q, shreg_q[7], POLY);
                shreg_d  = {shreg_q[6:0], 1'b0};
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    if (last_q) begin
                        state_d   = StDone;
                        crc_out_d = crc_d ^ XOROUT;
                    end else begin
                        state_d = StFrame;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign din_ready_o = (state_q == StFrame);
    assign done_o      = (state_q == StDone);
    assign busy_o      = (state_q != StIdle);
    assign crc_out_o   = crc_out_q;

endmodule

// File: tb/tb_crc16_engine.sv
// Directed bench for crc16_engine: two instances (XOROUT 0000 and FFFF) share one stimulus stream.
module tb_crc16_engine;
    import crc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_last;

    logic        ready_a, done_a, busy_a;
    logic [15:0] crc_a;
    logic        ready_b, done_b, busy_b;
    logic [15:0] crc_b;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    crc16_engine #(.XOROUT(16'h0000)) u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .din_i       (din),
        .din_valid_i (din_valid),
        .din_last_i  (din_last),
        .din_ready_o (ready_a),
        .crc_out_o   (crc_a),
        .done_o      (done_a),
        .busy_o      (busy_a)
    );

    crc16_engine #(.XOROUT(16'hFFFF)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .din_i       (din),
        .din_valid_i (din_valid),
        .din_last_i  (din_last),
        .din_ready_o (ready_b),
        .crc_out_o   (crc_b),
        .done_o      (done_b),
        .busy_o      (busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model_crc(input logic [7:0] bytes[$], input logic [15:0] xo);
        logic [15:0] c;
        c = CRC16_CCITT_INIT;
        foreach (bytes[i])
            for (int b = 7; b >= 0; b--) c = crc16_bit_step(c, bytes[i][b], CRC16_CCITT_POLY);
        return c ^ xo;
    endfunction

    task automatic do_start(output int lat);
        int n = 0;
        start = 1'b1;
        while (!ready_a && n < 10) begin
            tick();
            n++;
        end
        start = 1'b0;
        lat = n;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input bit stall,
                             output int acc_edge);
        bit rdy;
        int n = 0;
        if (stall) begin
            din_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        din       = b;
        din_last  = last;
        din_valid = 1'b1;
        do begin
            rdy = ready_a;
            tick();
            n++;
        end while (!rdy && n < 40);
        check("byte_accept", {31'd0, rdy}, 32'd1);
        acc_edge = cyc;
        // valid is still high here while the engine is shifting
        if (stall) check("ready_low_in_shift", {31'd0, ready_a}, 32'd0);
    endtask

    task automatic run_frame(input logic [7:0] bytes[$], input bit stall, input int glitch_at,
                             output int first_acc, output int last_acc, output int done_edge);
        int n = 0;
        int lat;
        int acc;
        while (busy_a && n < 40) begin
            tick();
            n++;
        end
        do_start(lat);
        check("start_to_ready", lat, 1);
        check("busy_after_start", {31'd0, busy_a}, 32'd1);
        foreach (bytes[i]) begin
            send_byte(bytes[i], (i == bytes.size() - 1), stall, acc);
            if (i == 0) first_acc = acc;
            last_acc = acc;
            if (i == glitch_at) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        din_valid = 1'b0;
        n = 0;
        while (!done_a && n < 40) begin
            tick();
            n++;
        end
        check("done_seen", {31'd0, done_a}, 32'd1);
        check("busy_in_done", {31'd0, busy_a}, 32'd1);
        done_edge = cyc;
    endtask

    logic [7:0] s_check[$];
    logic [7:0] s_zero[$];
    logic [7:0] s_misc[$];

    initial begin
        int fa, la, de, de1, de2, ndone;
        s_check = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        s_zero  = '{8'h00};
        s_misc  = '{8'hA5, 8'h3C, 8'hFF};
        start = 1'b0;
        din = 8'h00;
        din_valid = 1'b0;
        din_last = 1'b0;

        // Reset state, then idle with no activity
        #12;
        check("rst_crc_out", crc_a, 16'h0000);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_ready", {31'd0, ready_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        rst_n = 1'b1;
        repeat (20) tick();
        check("idle_crc_out", crc_a, 16'h0000);
        check("idle_flags", {29'd0, done_a, ready_a, busy_a}, 32'd0);

        // Single zero byte
        run_frame(s_zero, 1'b0, -1, fa, la, de);
        check("zero_crc", crc_a, 16'hE1F0);
        check("zero_crc_xorout", crc_b, 16'h1E0F);
        check("zero_done_latency", de - la, 8);
        tick();
        check("done_width", {31'd0, done_a}, 32'd0);
        check("busy_after_done", {31'd0, busy_a}, 32'd0);

        // "123456789", valid held high: 9 bytes x 9 cycles, done 80 edges after first accept
        run_frame(s_check, 1'b0, -1, fa, la, de);
        check("check_crc", crc_a, 16'h29B1);
        check("check_crc_xorout", crc_b, 16'hD64E);
        check("check_latency", de - fa, 80);
        repeat (5) tick();
        check("crc_out_hold", crc_a, 16'h29B1);

        // Random valid gaps
        run_frame(s_check, 1'b1, -1, fa, la, de);
        check("stall_crc", crc_a, 16'h29B1);

        // start pulsed mid-frame must be ignored
        run_frame(s_check, 1'b0, 3, fa, la, de);
        check("glitch_start_crc", crc_a, 16'h29B1);

        // Reset in the middle of SHIFT drops the frame
        tick();
        do_start(fa);
        send_byte(8'h5A, 1'b1, 1'b0, la);
        din_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_crc_out", crc_a, 16'h0000);
        check("midrst_flags", {29'd0, done_a, ready_a, busy_a}, 32'd0);
        tick();
        rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            tick();
            if (done_a) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        run_frame(s_zero, 1'b0, -1, fa, la, de);
        check("post_rst_crc", crc_a, 16'hE1F0);

        // Multi-byte frame against the reference model
        run_frame(s_misc, 1'b1, -1, fa, la, de);
        check("model_crc", crc_a, model_crc(s_misc, 16'h0000));
        check("model_crc_xorout", crc_b, model_crc(s_misc, 16'hFFFF));

        // Back-to-back frames on the XOROUT=FFFF instance
        run_frame(s_check, 1'b0, -1, fa, la, de1);
        check("b2b_crc1", crc_b, 16'hD64E);
        run_frame(s_check, 1'b0, -1, fa, la, de2);
        check("b2b_crc2", crc_b, 16'hD64E);
        check("b2b_done_spacing", {31'd0, (de2 - de1) >= 12}, 32'd1);
        tick();
        check("b2b_done_width", {31'd0, done_b}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
